// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: ROM address type, field helpers and loader state encoding.
package rom_loader_pkg;
  localparam int ROM_ADDR_BITS = 12;
  localparam int MAX_LOAD_LEN = 4096;
  typedef logic [ROM_ADDR_BITS-1:0] rom_addr_t;
  typedef enum logic [1:0] {IDLE, LOAD, RELEASE} loader_state_t;
  function automatic logic [3:0] chip_of(rom_addr_t a);
    return a[11:8];
  endfunction
  function automatic logic [7:0] offset_of(rom_addr_t a);
    return a[7:0];
  endfunction
endpackage

// File: rtl/rom_loader_if.sv
// rom_loader_if: host program byte stream with valid/ready handshake.
interface rom_loader_if;
  logic [7:0] s_data;
  logic s_valid;
  logic s_ready;
  modport master(output s_data, s_valid, input s_ready);
  modport slave(input s_data, s_valid, output s_ready);
endinterface

// File: rtl/rom_loader_rst_stretch.sv
// rom_loader_rst_stretch: loadable down-counter flagging the cycle before it reaches zero.
module rom_loader_rst_stretch #(
  parameter int HOLD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  output logic last
);
  localparam int W = $clog2(HOLD + 1);
  logic [W-1:0] cnt;
  assign last = cnt == W'(1);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (load) cnt <= W'(HOLD);
    else if (cnt != '0) cnt <= cnt - W'(1);
endmodule

// File: rtl/rom_loader.sv
// rom_loader: streams host bytes into the MCS-4 ROM debug port, holding cpu_rst until the load settles.
module rom_loader import rom_loader_pkg::*; #(
  parameter int NUM_ROMS = 16,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic            cfg_abort,
  input  rom_addr_t       cfg_base_addr,
  input  logic [12:0]     cfg_len,
  rom_loader_if.slave     s,
  output logic [2:0][3:0] dbg_addr,
  output logic [7:0]      dbg_wdata,
  output logic            dbg_wen,
  output logic            cpu_rst,
  output logic            busy,
  output logic            done,
  output logic [7:0]      checksum,
  output logic            err_range
);
  loader_state_t state;
  rom_addr_t cur_addr;
  logic [12:0] remaining;
  logic beat, go, last_beat, rel_load, rel_last;
  assign s.s_ready = state == LOAD;
  assign busy = state != IDLE;
  assign beat = s.s_valid && s.s_ready && !cfg_abort;
  assign go = state == IDLE && cfg_start && !cfg_abort;
  assign last_beat = beat && remaining == 13'd1;
  assign rel_load = (go && cfg_len == 13'd0) || last_beat;
  rom_loader_rst_stretch #(.HOLD(RST_HOLD_CYCLES)) u_stretch (
    .clk(clk), .rst(rst), .load(rel_load), .clr(cfg_abort), .last(rel_last)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cur_addr <= '0;
      remaining <= '0;
      dbg_addr <= '0;
      dbg_wdata <= '0;
      dbg_wen <= 1'b0;
      cpu_rst <= 1'b1;
      done <= 1'b0;
      checksum <= '0;
      err_range <= 1'b0;
    end else begin
      dbg_wen <= beat;
      done <= 1'b0;
      if (beat) begin
        dbg_addr <= cur_addr;
        dbg_wdata <= s.s_data;
        cur_addr <= cur_addr + 12'd1;
        remaining <= remaining - 13'd1;
        checksum <= checksum + s.s_data;
        if (32'(chip_of(cur_addr)) >= NUM_ROMS) err_range <= 1'b1;
      end
      if (cfg_abort) state <= IDLE;
      else if (go) begin
        state <= cfg_len == 13'd0 ? RELEASE : LOAD;
        cur_addr <= cfg_base_addr;
        remaining <= cfg_len;
        checksum <= '0;
        err_range <= 1'b0;
        cpu_rst <= 1'b1;
      end else if (last_beat) state <= RELEASE;
      else if (state == RELEASE && rel_last) begin
        state <= IDLE;
        cpu_rst <= 1'b0;
        done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed checks of load sequencing, wrap, backpressure, range error, abort and reset.
module tb_rom_loader;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [11:0] cfg_base_addr = '0;
  logic [12:0] cfg_len = '0;
  logic [2:0][3:0] dbg_addr;
  logic [7:0] dbg_wdata, checksum;
  logic dbg_wen, cpu_rst, busy, done, err_range;
  int total = 0, bad = 0;
  rom_loader_if bus();
  rom_loader #(.NUM_ROMS(2), .RST_HOLD_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len), .s(bus.slave),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_wen(dbg_wen),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .checksum(checksum),
    .err_range(err_range)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, ".s_ready"}, 32'(bus.s_ready), 0);
    chk({tag, ".wen"}, 32'(dbg_wen), 0);
    chk({tag, ".addr"}, 32'(dbg_addr), 0);
    chk({tag, ".wdata"}, 32'(dbg_wdata), 0);
    chk({tag, ".cpu_rst"}, 32'(cpu_rst), 1);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".checksum"}, 32'(checksum), 0);
    chk({tag, ".err"}, 32'(err_range), 0);
  endtask
  task automatic start(input logic [11:0] base, input logic [12:0] len);
    cfg_start = 1'b1;
    cfg_base_addr = base;
    cfg_len = len;
    step();
    cfg_start = 1'b0;
    chk("start.busy", 32'(busy), 1);
    chk("start.cpu_rst", 32'(cpu_rst), 1);
  endtask
  task automatic send(input string tag, input logic [7:0] d, input logic [11:0] a);
    bus.s_valid = 1'b1;
    bus.s_data = d;
    step();
    chk({tag, ".wen"}, 32'(dbg_wen), 1);
    chk({tag, ".addr"}, 32'(dbg_addr), 32'(a));
    chk({tag, ".wdata"}, 32'(dbg_wdata), 32'(d));
  endtask
  task automatic gap(input string tag);
    bus.s_valid = 1'b0;
    step();
    chk({tag, ".gap_wen"}, 32'(dbg_wen), 0);
  endtask
  task automatic release_check(input string tag);
    bus.s_valid = 1'b0;
    chk({tag, ".rel_s_ready"}, 32'(bus.s_ready), 0);
    for (int i = 1; i < 16; i++) begin
      step();
      chk({tag, ".hold_cpu_rst"}, 32'(cpu_rst), 1);
      chk({tag, ".hold_done"}, 32'(done), 0);
    end
    step();
    chk({tag, ".rel_cpu_rst"}, 32'(cpu_rst), 0);
    chk({tag, ".rel_done"}, 32'(done), 1);
    chk({tag, ".rel_busy"}, 32'(busy), 0);
    step();
    chk({tag, ".post_done"}, 32'(done), 0);
    chk({tag, ".post_wen"}, 32'(dbg_wen), 0);
  endtask
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    repeat (3) step();
    reset_vals("reset");
    rst = 1'b0;
    step();
    chk("idle.s_ready", 32'(bus.s_ready), 0);
    start(12'h000, 13'd4);
    chk("t1.s_ready", 32'(bus.s_ready), 1);
    send("t1.b0", 8'hD1, 12'h000);
    send("t1.b1", 8'h20, 12'h001);
    send("t1.b2", 8'h05, 12'h002);
    send("t1.b3", 8'h40, 12'h003);
    chk("t1.checksum", 32'(checksum), 'h36);
    release_check("t1");
    start(12'h1FE, 13'd3);
    send("t2a.b0", 8'hA0, 12'h1FE);
    send("t2a.b1", 8'hA1, 12'h1FF);
    chk("t2a.chip1", 32'(dbg_addr[2]), 1);
    send("t2a.b2", 8'hA2, 12'h200);
    chk("t2a.chip2", 32'(dbg_addr[2]), 2);
    chk("t2a.checksum", 32'(checksum), 'hE3);
    release_check("t2a");
    start(12'hFFF, 13'd2);
    chk("t2b.err_clr", 32'(err_range), 0);
    send("t2b.b0", 8'hB0, 12'hFFF);
    send("t2b.b1", 8'hB1, 12'h000);
    release_check("t2b");
    start(12'h010, 13'd3);
    send("t3.b0", 8'h11, 12'h010);
    gap("t3.g0");
    cfg_start = 1'b1;
    cfg_base_addr = 12'h800;
    cfg_len = 13'd1;
    gap("t3.g1");
    cfg_start = 1'b0;
    send("t3.b1", 8'h22, 12'h011);
    gap("t3.g2");
    send("t3.b2", 8'h33, 12'h012);
    chk("t3.checksum", 32'(checksum), 'h66);
    release_check("t3");
    start(12'h1FF, 13'd2);
    send("t4.b0", 8'hC0, 12'h1FF);
    chk("t4.err_lo", 32'(err_range), 0);
    send("t4.b1", 8'hC1, 12'h200);
    chk("t4.err_hi", 32'(err_range), 1);
    release_check("t4");
    chk("t4.err_sticky", 32'(err_range), 1);
    start(12'h020, 13'd5);
    chk("t5.err_clr", 32'(err_range), 0);
    send("t5.b0", 8'h01, 12'h020);
    send("t5.b1", 8'h02, 12'h021);
    cfg_abort = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = 8'hEE;
    step();
    cfg_abort = 1'b0;
    bus.s_valid = 1'b0;
    chk("t5.abort_wen", 32'(dbg_wen), 0);
    chk("t5.abort_busy", 32'(busy), 0);
    chk("t5.abort_cpu_rst", 32'(cpu_rst), 1);
    chk("t5.abort_done", 32'(done), 0);
    chk("t5.abort_checksum", 32'(checksum), 'h03);
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    cfg_len = 13'd0;
    step();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    chk("t5.both_busy", 32'(busy), 0);
    step();
    chk("t5.idle_done", 32'(done), 0);
    start(12'h000, 13'd0);
    chk("t5.zero_checksum", 32'(checksum), 0);
    release_check("t5z");
    start(12'h030, 13'd4);
    send("t6.b0", 8'h55, 12'h030);
    rst = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = 8'h66;
    step();
    reset_vals("t6.rst");
    rst = 1'b0;
    step();
    chk("t6.after_wen", 32'(dbg_wen), 0);
    chk("t6.after_s_ready", 32'(bus.s_ready), 0);
    chk("t6.after_busy", 32'(busy), 0);
    bus.s_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
